// File: rtl/noc_pkg.sv
// Shared definitions for the NoC reader: packet field layout and
// the per-source tracker state encoding.
package noc_pkg;

    localparam int VALID_BIT = 0;
    localparam int DST_LSB   = 1;
    localparam int SRC_LSB   = 3;
    localparam int SEQ_LSB   = 5;
    localparam int DST_W     = 2;
    localparam int SRC_W     = 2;

    typedef enum logic {
        UNSYNC = 1'b0,
        LOCKED = 1'b1
    } trk_state_t;

endpackage

// File: rtl/noc_src_tracker.sv
// Per-source sequence tracker: UNSYNC/LOCKED FSM, expected seq, in-order count.
// Ports: clk, reset, clear, hit (packet for this source), seq, in_order, rx_cnt.
module noc_src_tracker
    import noc_pkg::*;
#(
    parameter int SEQ_WIDTH  = 11,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  hit,
    input  logic [SEQ_WIDTH-1:0]  seq,
    output logic                  in_order,
    output logic [STAT_WIDTH-1:0] rx_cnt
);

    trk_state_t             state_q, state_d;
    logic [SEQ_WIDTH-1:0]   expect_q, expect_d;
    logic [STAT_WIDTH-1:0]  cnt_d;

    // Combinational so the top can flag the packet in the same cycle.
    assign in_order = (state_q == UNSYNC) || (seq == expect_q);

    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        cnt_d    = rx_cnt;
        if (hit) begin
            // Both in-order and out-of-order packets resync the expectation.
            state_d  = LOCKED;
            expect_d = seq + 1'b1;
            if (in_order && !(&rx_cnt))
                cnt_d = rx_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q  <= UNSYNC;
            expect_q <= '0;
            rx_cnt   <= '0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            rx_cnt   <= cnt_d;
        end
    end

endmodule

// File: rtl/noc_reader.sv
// NoC output-port sink: decodes packets, checks routing and per-source order,
// keeps saturating statistics, captures the first failing packet.
// Ports: clk, reset, my_id, enable, clear, dataIn; rx_valid/rx_src/rx_seq,
// seq_err, misroute, total_cnt, err_cnt, err_valid, err_pkt; stat_sel -> stat_data.
module noc_reader
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_WIDTH  = 11,
    parameter int NUM_SRC    = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DST_W-1:0]      my_id,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic                  rx_valid,
    output logic [SRC_W-1:0]      rx_src,
    output logic [SEQ_WIDTH-1:0]  rx_seq,
    output logic                  seq_err,
    output logic                  misroute,
    output logic [STAT_WIDTH-1:0] total_cnt,
    output logic [STAT_WIDTH-1:0] err_cnt,
    output logic                  err_valid,
    output logic [DATA_WIDTH-1:0] err_pkt,
    input  logic [SRC_W-1:0]      stat_sel,
    output logic [STAT_WIDTH-1:0] stat_data
);

    logic [DST_W-1:0]     dst;
    logic [SRC_W-1:0]     src;
    logic [SEQ_WIDTH-1:0] seq;
    logic                 accept, misr, good, ok, bad, fail;
    logic [NUM_SRC-1:0]   in_order;
    logic [NUM_SRC-1:0][STAT_WIDTH-1:0] rx_cnt;

    assign dst    = dataIn[DST_LSB +: DST_W];
    assign src    = dataIn[SRC_LSB +: SRC_W];
    assign seq    = dataIn[SEQ_LSB +: SEQ_WIDTH];
    assign accept = dataIn[VALID_BIT] & enable & ~clear & ~reset;
    assign misr   = (dst != my_id);
    // Misrouted packets never reach the sequence check.
    assign good   = accept & ~misr;
    assign ok     = good & in_order[src];
    assign bad    = good & ~in_order[src];
    assign fail   = bad | (accept & misr);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_trk
        noc_src_tracker #(
            .SEQ_WIDTH  (SEQ_WIDTH),
            .STAT_WIDTH (STAT_WIDTH)
        ) u_trk (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .hit      (good && (src == SRC_W'(i))),
            .seq      (seq),
            .in_order (in_order[i]),
            .rx_cnt   (rx_cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rx_valid  <= 1'b0;
            rx_src    <= '0;
            rx_seq    <= '0;
            seq_err   <= 1'b0;
            misroute  <= 1'b0;
            total_cnt <= '0;
            err_cnt   <= '0;
            err_valid <= 1'b0;
            err_pkt   <= '0;
            stat_data <= '0;
        end else begin
            rx_valid  <= ok;
            seq_err   <= bad;
            misroute  <= accept & misr;
            stat_data <= rx_cnt[stat_sel];
            if (ok) begin
                rx_src <= src;
                rx_seq <= seq;
            end
            if (accept && !(&total_cnt))
                total_cnt <= total_cnt + 1'b1;
            if (fail && !(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
            if (fail && !err_valid) begin
                err_valid <= 1'b1;
                err_pkt   <= dataIn;
            end
        end
    end

endmodule
